// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the fetch-decode queue.
// The queue takes the slave side; the fetch/decode pair takes the master side.
interface fetch_decode_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_flush;
  logic          i_valid;
  logic [31:0]   i_pc;
  logic [31:0]   i_inst;
  logic          o_ready;
  logic          o_valid;
  logic [31:0]   o_pc;
  logic [31:0]   o_inst;
  logic          i_ready;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_flush, i_valid, i_pc, i_inst, i_ready,
    output o_ready, o_valid, o_pc, o_inst, o_count
  );

  modport master (
    output i_flush, i_valid, i_pc, i_inst, i_ready,
    input  o_ready, o_valid, o_pc, o_inst, o_count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Small FIFO of {pc, inst} pairs between fetch and decode, with branch flush.
// Decode sees a NOP when the queue is empty; no same-cycle bypass.
module fetch_decode_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fetch_decode_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready depends only on occupancy, so a full queue never passes through.
  assign bus.o_ready = (count_q < CW'(DEPTH));
  assign bus.o_valid = (count_q != '0);
  assign bus.o_count = count_q;
  assign bus.o_pc    = bus.o_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign bus.o_inst  = bus.o_valid ? mem_q[rd_ptr_q][31:0]  : NOP_INSTR;

  assign push = bus.i_valid & bus.o_ready;
  assign pop  = bus.o_valid & bus.i_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      // The flushing cycle's fetch word is wrong-path; drop it.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.i_pc, bus.i_inst};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
